piso_scan_serializer: RTL and testbench

PISO_SCAN_SERIALIZER -- requirements
Module: piso_scan_serializer

---
 rtl/piso_scan_serializer_pkg.sv | 22 ++
 rtl/mux8to1.sv | 32 +++
 rtl/piso_scan_serializer.sv | 121 ++++++++++++
 tb/tb_piso_scan_serializer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_scan_serializer_pkg.sv
// Shared types and constants for the PISO scan serializer.
// The PARITY state exists only when PISO_PARITY_EN is defined.
package piso_pkg;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

  localparam logic [2:0] SEL_FIRST_LSB = 3'd0;
  localparam logic [2:0] SEL_FIRST_MSB = 3'd7;
  localparam int         DATA_BEATS    = 8;

endpackage

// File: rtl/mux8to1.sv
// Plain 8:1 bit multiplexer; {s2,s1,s0} selects d0..d7 onto y.
module mux8to1 (
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  input  logic s2,
  input  logic s1,
  input  logic s0,
  output logic y
);

  always_comb begin
    y = d0;
    case ({s2, s1, s0})
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      3'd5:    y = d5;
      3'd6:    y = d6;
      3'd7:    y = d7;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/piso_scan_serializer.sv
// Parallel-in serial-out scan serializer with valid/ready on both sides.
// Optional trailing even-parity beat is compiled in with PISO_PARITY_EN.
module piso_scan_serializer
  import piso_pkg::*;
#(
  parameter logic LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        ser_data,
  output logic [2:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_cnt
);

  localparam logic [2:0] SEL_FIRST = LSB_FIRST ? SEL_FIRST_LSB : SEL_FIRST_MSB;
  localparam logic [2:0] SEL_LAST  = LSB_FIRST ? SEL_FIRST_MSB : SEL_FIRST_LSB;

  state_t      state;
  state_t      state_next;
  logic [7:0]  hold;
  logic        mux_y;
  logic        last_beat;
  logic        load;
  logic        final_acc;
  logic        last_data;

  assign last_data = (state == ST_SHIFT) && (sel == SEL_LAST);

`ifdef PISO_PARITY_EN
  assign last_beat = (state == ST_PARITY);
`else
  assign last_beat = last_data;
`endif

  // A new word may load in the same cycle the previous frame's last beat leaves.
  assign in_ready  = (state == ST_IDLE) || (last_beat && ser_ready);
  assign load      = in_valid && in_ready;
  assign final_acc = last_beat && ser_ready;
  assign ser_valid = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (load) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ser_ready && (sel == SEL_LAST)) begin
`ifdef PISO_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = load ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        if (ser_ready) state_next = load ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel      <= 3'd0;
      hold     <= 8'd0;
      done     <= 1'b0;
      word_cnt <= 16'd0;
    end else begin
      state <= state_next;
      done  <= final_acc;
      if (final_acc) word_cnt <= word_cnt + 16'd1;
      // sel never wraps inside a frame: it only steps before the last data beat.
      if (load) begin
        hold <= in_data;
        sel  <= SEL_FIRST;
      end else if ((state == ST_SHIFT) && ser_ready && (sel != SEL_LAST)) begin
        sel <= LSB_FIRST ? (sel + 3'd1) : (sel - 3'd1);
      end
    end
  end

  mux8to1 u_mux (
    .d0 (hold[0]),
    .d1 (hold[1]),
    .d2 (hold[2]),
    .d3 (hold[3]),
    .d4 (hold[4]),
    .d5 (hold[5]),
    .d6 (hold[6]),
    .d7 (hold[7]),
    .s2 (sel[2]),
    .s1 (sel[1]),
    .s0 (sel[0]),
    .y  (mux_y)
  );

  always_comb begin
    ser_data = IDLE_LEVEL;
    case (state)
      ST_SHIFT:  ser_data = mux_y;
`ifdef PISO_PARITY_EN
      ST_PARITY: ser_data = ^hold;
`endif
      default:   ser_data = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_piso_scan_serializer.sv
// Directed bench for piso_scan_serializer: an LSB-first and an MSB-first instance.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_piso_scan_serializer;

`ifdef PISO_PARITY_EN
  localparam int BEATS = 9;
`else
  localparam int BEATS = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_ser_valid, a_ser_ready, a_ser_data;
  logic        a_busy, a_done;
  logic [7:0]  a_in_data;
  logic [2:0]  a_sel;
  logic [15:0] a_word_cnt;

  logic        b_in_valid, b_in_ready, b_ser_valid, b_ser_ready, b_ser_data;
  logic        b_busy, b_done;
  logic [7:0]  b_in_data;
  logic [2:0]  b_sel;
  logic [15:0] b_word_cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] a_cnt = 16'd0;

  always #5 clk = ~clk;

  piso_scan_serializer #(.LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .ser_valid(a_ser_valid), .ser_ready(a_ser_ready),
    .ser_data(a_ser_data), .sel(a_sel), .busy(a_busy), .done(a_done),
    .word_cnt(a_word_cnt)
  );

  piso_scan_serializer #(.LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .ser_valid(b_ser_valid), .ser_ready(b_ser_ready),
    .ser_data(b_ser_data), .sel(b_sel), .busy(b_busy), .done(b_done),
    .word_cnt(b_word_cnt)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", a_in_ready); end
    total++; if (a_ser_valid !== 1'b0) begin bad++; $display("FAIL rst_ser_valid got=%b want=0", a_ser_valid); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", a_done); end
    total++; if (a_word_cnt !== 16'd0) begin bad++; $display("FAIL rst_word_cnt got=%0d want=0", a_word_cnt); end
    total++; if (a_sel !== 3'd0) begin bad++; $display("FAIL rst_sel got=%0d want=0", a_sel); end
    total++; if (a_ser_data !== 1'b0) begin bad++; $display("FAIL rst_idle_level got=%b want=0", a_ser_data); end
    total++; if (b_sel !== 3'd0) begin bad++; $display("FAIL rst_msb_sel got=%0d want=0", b_sel); end
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL rst_msb_in_ready got=%b want=1", b_in_ready); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 8'hA5; a_ser_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    // Beat 5 is on the wire; reset collides with a beat accept and a new offer.
    #1;
    total++; if (a_sel !== 3'd4) begin bad++; $display("FAIL rmf_sel_before got=%0d want=4", a_sel); end
    rst = 1'b1; a_in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_in_valid = 1'b0;
    #1;
    total++; if (a_ser_valid !== 1'b0) begin bad++; $display("FAIL rmf_ser_valid got=%b want=0", a_ser_valid); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rmf_in_ready got=%b want=1", a_in_ready); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rmf_done got=%b want=0", a_done); end
    total++; if (a_word_cnt !== 16'd0) begin bad++; $display("FAIL rmf_word_cnt got=%0d want=0", a_word_cnt); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rmf_busy got=%b want=0", a_busy); end
    for (int i = 0; i < BEATS; i++) begin
      @(negedge clk); #1;
      total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rmf_late_done cyc=%0d got=%b want=0", i, a_done); end
    end
    total++; if (a_word_cnt !== 16'd0) begin bad++; $display("FAIL rmf_word_cnt_late got=%0d want=0", a_word_cnt); end
  endtask

  task automatic test_single_frame();
    logic exp_b [0:7];
    exp_b = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 8'hA5; a_ser_ready = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL sf_in_ready got=%b want=1", a_in_ready); end
    total++; if (a_ser_valid !== 1'b0) begin bad++; $display("FAIL sf_pre_valid got=%b want=0", a_ser_valid); end
    @(negedge clk);
    a_in_valid = 1'b0; a_in_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (a_ser_valid !== 1'b1) begin bad++; $display("FAIL sf_valid beat=%0d got=%b want=1", i, a_ser_valid); end
      total++; if (a_ser_data !== exp_b[i]) begin bad++; $display("FAIL sf_data beat=%0d got=%b want=%b", i, a_ser_data, exp_b[i]); end
      total++; if (a_sel !== 3'(i)) begin bad++; $display("FAIL sf_sel beat=%0d got=%0d want=%0d", i, a_sel, i); end
      total++; if (a_done !== 1'b0) begin bad++; $display("FAIL sf_done_early beat=%0d got=%b want=0", i, a_done); end
      @(negedge clk);
    end
`ifdef PISO_PARITY_EN
    #1;
    total++; if (a_ser_data !== 1'b0) begin bad++; $display("FAIL sf_parity got=%b want=0", a_ser_data); end
    @(negedge clk);
`endif
    #1;
    a_cnt = a_cnt + 16'd1;
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL sf_done got=%b want=1", a_done); end
    total++; if (a_ser_valid !== 1'b0) begin bad++; $display("FAIL sf_post_valid got=%b want=0", a_ser_valid); end
    total++; if (a_word_cnt !== a_cnt) begin bad++; $display("FAIL sf_word_cnt got=%0d want=%0d", a_word_cnt, a_cnt); end
    total++; if (a_sel !== 3'd7) begin bad++; $display("FAIL sf_sel_held got=%0d want=7", a_sel); end
    @(negedge clk); #1;
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL sf_done_pulse got=%b want=0", a_done); end
  endtask

  task automatic test_msb_first();
    logic exp_b [0:7];
    exp_b = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 8'h81; b_ser_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (b_ser_data !== exp_b[i]) begin bad++; $display("FAIL msb_data beat=%0d got=%b want=%b", i, b_ser_data, exp_b[i]); end
      total++; if (b_sel !== 3'(7 - i)) begin bad++; $display("FAIL msb_sel beat=%0d got=%0d want=%0d", i, b_sel, 7 - i); end
      @(negedge clk);
    end
`ifdef PISO_PARITY_EN
    #1;
    total++; if (b_ser_data !== 1'b0) begin bad++; $display("FAIL msb_parity got=%b want=0", b_ser_data); end
    @(negedge clk);
`endif
    #1;
    total++; if (b_done !== 1'b1) begin bad++; $display("FAIL msb_done got=%b want=1", b_done); end
    total++; if (b_word_cnt !== 16'd1) begin bad++; $display("FAIL msb_word_cnt got=%0d want=1", b_word_cnt); end
  endtask

  task automatic test_backpressure();
    logic exp_b [0:7];
    exp_b = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 8'h3C; a_ser_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        for (int s = 0; s < 3; s++) begin
          a_ser_ready = 1'b0;
          #1;
          total++; if (a_ser_valid !== 1'b1) begin bad++; $display("FAIL bp_stall_valid s=%0d got=%b want=1", s, a_ser_valid); end
          total++; if (a_ser_data !== 1'b1) begin bad++; $display("FAIL bp_stall_data s=%0d got=%b want=1", s, a_ser_data); end
          total++; if (a_sel !== 3'd3) begin bad++; $display("FAIL bp_stall_sel s=%0d got=%0d want=3", s, a_sel); end
          @(negedge clk);
        end
        a_ser_ready = 1'b1;
      end
      #1;
      total++; if (a_ser_data !== exp_b[i]) begin bad++; $display("FAIL bp_data beat=%0d got=%b want=%b", i, a_ser_data, exp_b[i]); end
      total++; if (a_sel !== 3'(i)) begin bad++; $display("FAIL bp_sel beat=%0d got=%0d want=%0d", i, a_sel, i); end
      total++; if (a_done !== 1'b0) begin bad++; $display("FAIL bp_done_early beat=%0d got=%b want=0", i, a_done); end
      @(negedge clk);
    end
`ifdef PISO_PARITY_EN
    #1;
    total++; if (a_ser_data !== 1'b0) begin bad++; $display("FAIL bp_parity got=%b want=0", a_ser_data); end
    @(negedge clk);
`endif
    #1;
    a_cnt = a_cnt + 16'd1;
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want=1", a_done); end
    total++; if (a_word_cnt !== a_cnt) begin bad++; $display("FAIL bp_word_cnt got=%0d want=%0d", a_word_cnt, a_cnt); end
  endtask

  task automatic test_back_to_back();
    logic exp_bit;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 8'hFF; a_ser_ready = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%b want=1", a_in_ready); end
    @(negedge clk);
    for (int c = 0; c < 2 * BEATS; c++) begin
      if (c < BEATS) a_in_data = 8'h00;
      else a_in_valid = 1'b0;
      #1;
      // FF and 00 both have even parity, so any parity beat is 0.
      exp_bit = ((c % BEATS) < 8) ? (c < BEATS) : 1'b0;
      total++; if (a_ser_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid cyc=%0d got=%b want=1", c, a_ser_valid); end
      total++; if (a_ser_data !== exp_bit) begin bad++; $display("FAIL b2b_data cyc=%0d got=%b want=%b", c, a_ser_data, exp_bit); end
      total++; if (a_done !== (c == BEATS)) begin bad++; $display("FAIL b2b_done cyc=%0d got=%b want=%b", c, a_done, (c == BEATS)); end
      total++; if (a_in_ready !== ((c % BEATS) == BEATS - 1)) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", c, a_in_ready, ((c % BEATS) == BEATS - 1)); end
      @(negedge clk);
    end
    #1;
    a_cnt = a_cnt + 16'd2;
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL b2b_done_second got=%b want=1", a_done); end
    total++; if (a_ser_valid !== 1'b0) begin bad++; $display("FAIL b2b_post_valid got=%b want=0", a_ser_valid); end
    total++; if (a_word_cnt !== a_cnt) begin bad++; $display("FAIL b2b_word_cnt got=%0d want=%0d", a_word_cnt, a_cnt); end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [0:1];
    logic       par   [0:1];
    words = '{8'h07, 8'h03};
    par   = '{1'b1, 1'b0};
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = words[w]; a_ser_ready = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      for (int i = 0; i < 8; i++) @(negedge clk);
      #1;
      total++; if (a_ser_valid !== 1'b1) begin bad++; $display("FAIL par_valid w=%0d got=%b want=1", w, a_ser_valid); end
      total++; if (a_ser_data !== par[w]) begin bad++; $display("FAIL par_bit w=%0d got=%b want=%b", w, a_ser_data, par[w]); end
      total++; if (a_done !== 1'b0) begin bad++; $display("FAIL par_done_early w=%0d got=%b want=0", w, a_done); end
      @(negedge clk); #1;
      a_cnt = a_cnt + 16'd1;
      total++; if (a_done !== 1'b1) begin bad++; $display("FAIL par_done w=%0d got=%b want=1", w, a_done); end
      total++; if (a_word_cnt !== a_cnt) begin bad++; $display("FAIL par_word_cnt w=%0d got=%0d want=%0d", w, a_word_cnt, a_cnt); end
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_ser_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_ser_ready = 1'b1;
    test_reset();
    test_reset_mid_frame();
    test_single_frame();
    test_msb_first();
    test_backpressure();
    test_back_to_back();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
